// File: rtl/g9_loader_pkg.sv
// Shared state encoding and framing constants for the G9 instruction-memory boot loader.
package g9_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_CNT_W      = $clog2(LEN_BYTES);
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    // States in which a new load may be launched by start.
    function automatic logic is_start_state(input state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word shift register: the first byte of a word ends up in bits [7:0].
module word_packer
    import g9_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift,
    input  logic              consume,
    input  logic [7:0]        data,
    output logic [WORD_W-1:0] word_next,
    output logic              last_byte,
    output logic              word_full
);

    logic [WORD_W-1:0]     word;
    logic [BYTE_CNT_W-1:0] count;

    // Bytes enter at the top and move down, so after a full word the oldest byte sits lowest.
    assign word_next = {data, word[WORD_W-1:8]};
    assign last_byte = (count == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word      <= '0;
            count     <= '0;
            word_full <= 1'b0;
        end else if (clear) begin
            word      <= '0;
            count     <= '0;
            word_full <= 1'b0;
        end else if (shift) begin
            word  <= word_next;
            count <= count + BYTE_CNT_W'(1);
            if (last_byte) begin
                word_full <= 1'b1;
            end
        end else if (consume) begin
            word_full <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream (16-bit word count, then LE words) written into the G9 instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader
    import g9_loader_pkg::*;
#(
    parameter int size    = 32,
    parameter int MemSize = 512
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    output logic            wea,
    output logic [size-1:0] addra,
    output logic [size-1:0] dina,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [15:0]     words_loaded
);

    localparam logic [15:0] MAX_WORDS = 16'(MemSize);

    state_t               state;
    logic [LEN_CNT_W-1:0] len_cnt;
    logic [7:0]           len_lo;
    logic [15:0]          word_count;
    logic [15:0]          index;
    logic [15:0]          index_next;
    logic [15:0]          len_value;
    logic                 take;
    logic                 start_load;
    logic                 pack_shift;
    logic                 pack_consume;
    logic                 last_byte;
    logic                 word_full;
    logic [WORD_W-1:0]    word_next;

    assign take         = in_valid && in_ready;
    assign start_load   = start && is_start_state(state);
    assign pack_shift   = take && (state == DATA);
    assign pack_consume = (state == WRITE);
    assign len_value    = {in_data, len_lo};
    assign index_next   = index + 16'd1;

    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_load),
        .shift     (pack_shift),
        .consume   (pack_consume),
        .data      (in_data),
        .word_next (word_next),
        .last_byte (last_byte),
        .word_full (word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;

    // Running XOR over length and data bytes; the trailing byte itself is excluded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= 8'h00;
        end else if (start_load) begin
            csum <= 8'h00;
        end else if (take && ((state == LEN) || (state == DATA))) begin
            csum <= csum ^ in_data;
        end
    end

    assign csum_ok = (csum == in_data);
`endif

    // All outputs are updated together with the state so they are glitch-free registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            wea          <= 1'b0;
            addra        <= '0;
            dina         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            index        <= 16'd0;
            word_count   <= 16'd0;
            len_lo       <= 8'h00;
            len_cnt      <= '0;
        end else begin
            wea <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        index        <= 16'd0;
                        words_loaded <= 16'd0;
                        len_cnt      <= '0;
                    end
                end
                LEN: begin
                    if (take) begin
                        if (len_cnt != LEN_CNT_W'(LEN_BYTES - 1)) begin
                            len_lo  <= in_data;
                            len_cnt <= len_cnt + LEN_CNT_W'(1);
                        end else begin
                            word_count <= len_value;
                            len_cnt    <= '0;
                            if (len_value > MAX_WORDS) begin
                                state    <= ERR;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                error    <= 1'b1;
                            end else if (len_value == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= CHK;
`else
                                state    <= DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
`endif
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (pack_shift && last_byte) begin
                        state    <= WRITE;
                        in_ready <= 1'b0;
                        wea      <= 1'b1;
                        addra    <= {{(size - 16){1'b0}}, index};
                        dina     <= size'(word_next);
                    end
                end
                WRITE: begin
                    if (word_full) begin
                        index        <= index_next;
                        words_loaded <= index_next;
                    end
                    if (index_next == word_count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= CHK;
                        in_ready <= 1'b1;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end else begin
                        state    <= DATA;
                        in_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (take) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (csum_ok) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; follows IMEM_LOADER_CHECKSUM_EN when it is defined.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int MEM_SIZE = 512;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, wea, busy, done, error;
    logic [31:0] addra, dina;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    logic [7:0]  stream[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          cap_cyc[$];
    int          xfer_cyc[$];
    bit          run_done, run_error, timed_out, first_ready, end_ready, end_busy;
    logic [15:0] run_words;
    int          end_cyc, consumed, ready_viol;

    typedef struct {
        int          n;
        logic [31:0] first;
        logic [31:0] step;
        bit          bad_chk;
        bit          gaps;
        bit          exp_done;
        bit          exp_error;
        int          exp_words;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] capPair(input int k);
        if (k < cap_addr.size()) return {cap_addr[k], cap_data[k]};
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Stream of n words first, first+step, ...; checksum appended when enabled, plus junk bytes.
    task automatic buildStream(input int n, input logic [31:0] first, input logic [31:0] step, input bit bad_chk);
        logic [7:0]  x;
        logic [31:0] w;
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        x = n[7:0] ^ n[15:8];
        if (n <= MEM_SIZE) begin
            for (int i = 0; i < n; i++) begin
                w = first + step * 32'(i);
                for (int b = 0; b < 4; b++) begin
                    stream.push_back(w[8*b +: 8]);
                    x = x ^ w[8*b +: 8];
                end
            end
            if (CHK_EN) stream.push_back(bad_chk ? (x ^ 8'h01) : x);
        end
        stream.push_back(8'h5A);
        stream.push_back(8'hC3);
    endtask

    // Pulse start, then offer the stream until done/error or the cycle budget runs out.
    task automatic applyStimulus(input bit gaps, input int budget);
        int pos;
        int cyc;
        bit xfer;
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
        xfer_cyc.delete();
        ready_viol = 0;
        timed_out = 0;
        run_done = 0;
        run_error = 0;
        run_words = 16'hFFFF;
        end_cyc = -1;
        end_ready = 1;
        end_busy = 1;
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        pos = 0;
        cyc = 0;
        forever begin
            if (pos < stream.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_data = stream[pos];
            end else begin
                in_valid = 1'b0;
                in_data = 8'h00;
            end
            @(negedge clk);
            if (cyc == 0) first_ready = in_ready;
            if (wea) begin
                cap_addr.push_back(addra);
                cap_data.push_back(dina);
                cap_cyc.push_back(cyc);
                if (in_ready) ready_viol++;
            end
            if (done || error) begin
                run_done = done;
                run_error = error;
                run_words = words_loaded;
                end_cyc = cyc;
                end_ready = in_ready;
                end_busy = busy;
                break;
            end
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            xfer = in_valid && in_ready;
            if (xfer) xfer_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (xfer) pos++;
            cyc++;
        end
        consumed = pos;
        in_valid = 1'b0;
    endtask

    // Reference: decode the stream by the framing rules and compare the observed run against it.
    task automatic checkRun(input string tag);
        int n, m_words, m_consumed, n_writes, lat_viol, last_evt;
        bit m_ok;
        logic [7:0]  x;
        logic [31:0] ew;
        n = int'(stream[0]) + 256 * int'(stream[1]);
        if (n > MEM_SIZE) begin
            m_ok = 0;
            m_words = 0;
            m_consumed = 2;
            n_writes = 0;
        end else begin
            m_words = n;
            n_writes = n;
            m_consumed = 2 + 4 * n + (CHK_EN ? 1 : 0);
            x = 8'h00;
            for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stream[i];
            m_ok = !CHK_EN || (x == stream[2 + 4 * n]);
        end
        checkOutput({tag, " timeout"}, 64'(timed_out), 64'(0));
        checkOutput({tag, " done/error"}, 64'({run_done, run_error}), 64'({m_ok, !m_ok}));
        checkOutput({tag, " words_loaded"}, 64'(run_words), 64'(m_words));
        checkOutput({tag, " write count"}, 64'(cap_addr.size()), 64'(n_writes));
        checkOutput({tag, " bytes consumed"}, 64'(consumed), 64'(m_consumed));
        checkOutput({tag, " busy/in_ready at end"}, 64'({end_busy, end_ready}), 64'(0));
        checkOutput({tag, " in_ready after start"}, 64'(first_ready), 64'(1));
        checkOutput({tag, " in_ready during wea"}, 64'(ready_viol), 64'(0));
        for (int k = 0; k < n_writes; k++) begin
            ew = {stream[5 + 4*k], stream[4 + 4*k], stream[3 + 4*k], stream[2 + 4*k]};
            checkOutput($sformatf("%s write %0d addr/data", tag, k), capPair(k), {32'(k), ew});
        end
        lat_viol = 0;
        last_evt = -100;
        for (int k = 0; k < cap_cyc.size(); k++) begin
            if (5 + 4*k >= xfer_cyc.size() || cap_cyc[k] != xfer_cyc[5 + 4*k] + 1) lat_viol++;
        end
        if (cap_cyc.size() > 0) last_evt = cap_cyc[cap_cyc.size() - 1];
        if (xfer_cyc.size() > 0 && xfer_cyc[xfer_cyc.size() - 1] > last_evt) last_evt = xfer_cyc[xfer_cyc.size() - 1];
        checkOutput({tag, " wea latency"}, 64'(lat_viol), 64'(0));
        checkOutput({tag, " end latency"}, 64'(end_cyc), 64'(last_evt + 1));
    endtask

    initial begin
        logic [7:0] mid[4];
        bit seen_wea;

        vecs[0] = '{1,     32'h0102_0304, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{3,     32'hA5A5_0000, 32'h0000_1111, 1'b0, 1'b1, 1'b1, 1'b0, 3};
        vecs[2] = '{0,     32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{513,   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{512,   32'h0000_0000, 32'h0001_0001, 1'b0, 1'b0, 1'b1, 1'b0, 512};
        vecs[5] = '{65535, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[6] = '{2,     32'hCAFE_F00D, 32'h0000_0001, 1'b1, 1'b1, !CHK_EN, CHK_EN, 2};
        vecs[7] = '{4,     32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 4};

        #2 reset = 1'b0;
        #10;
        checkOutput("reset ctrl bits", 64'({in_ready, wea, busy, done, error}), 64'(0));
        checkOutput("reset addra", 64'(addra), 64'(0));
        checkOutput("reset dina", 64'(dina), 64'(0));
        checkOutput("reset words_loaded", 64'(words_loaded), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] nominal load");
        stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CHK_EN) stream.push_back(8'h02 ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
        stream.push_back(8'h99);
        applyStimulus(1'b0, 200);
        checkRun("nominal");
        checkOutput("nominal word0", capPair(0), {32'h0, 32'h1234_5678});
        checkOutput("nominal word1", capPair(1), {32'h1, 32'hDEAD_BEEF});

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            buildStream(vecs[i].n, vecs[i].first, vecs[i].step, vecs[i].bad_chk);
            applyStimulus(vecs[i].gaps, 100 + 40 * ((vecs[i].n > MEM_SIZE) ? 0 : vecs[i].n));
            checkRun($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d table status", i), 64'({run_done, run_error}),
                        64'({vecs[i].exp_done, vecs[i].exp_error}));
            checkOutput($sformatf("vec%0d table words", i), 64'(run_words), 64'(vecs[i].exp_words));
        end

        $display("[TB] reset mid-word");
        mid = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        seen_wea = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = mid[i];
            @(negedge clk);
            if (wea) seen_wea = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #2;
        checkOutput("midreset ctrl bits", 64'({in_ready, wea, busy, done, error}), 64'(0));
        checkOutput("midreset addra/dina", {addra, dina}, 64'(0));
        checkOutput("midreset words_loaded", 64'(words_loaded), 64'(0));
        @(negedge clk);
        if (wea) seen_wea = 1;
        checkOutput("midreset no wea", 64'(seen_wea), 64'(0));
        reset = 1'b1;
        stream = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
        if (CHK_EN) stream.push_back(8'h01 ^ 8'h04 ^ 8'h03 ^ 8'h02 ^ 8'h01);
        applyStimulus(1'b0, 100);
        checkRun("after reset");
        checkOutput("after reset word0", capPair(0), {32'h0, 32'h0102_0304});

        $display("[TB] random loads");
        for (int r = 0; r < 12; r++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 513 + int'($urandom_range(0, 1000)) : int'($urandom_range(0, 6));
            buildStream(n, $urandom(), $urandom(), $urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 1) == 1, 100 + 40 * ((n > MEM_SIZE) ? 0 : n));
            checkRun($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
